// File: rtl/dram_read_pipe_if.sv
// Bundle of request-side and Avalon-MM signals for dram_read_pipe.
// The master modport is the pipe's own view: it takes read requests and
// drives the Avalon-MM read master. The slave modport is the environment's view.
interface dram_read_pipe_if #(
  parameter int MAXBURST_LOG   = 4,
  parameter int READNUM_SIZE   = 31,
  parameter int DRAM_ADDRSPACE = 64,
  parameter int DRAM_DATAWIDTH = 512
);
  logic                          READ_REQ;
  logic [DRAM_ADDRSPACE-1:0]     READ_INITADDR;
  logic [READNUM_SIZE:0]         READ_NUM;
  logic [DRAM_ADDRSPACE-1:0]     READ_STRIDE;
  logic [DRAM_DATAWIDTH-1:0]     READ_DATA;
  logic                          READ_DATAEN;
  logic                          READ_RDY;
  logic                          READ_DONE;
  logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_READDATA;
  logic                          AVALON_MM_READDATAVALID;
  logic                          AVALON_MM_WAITREQUEST;
  logic [DRAM_ADDRSPACE-1:0]     AVALON_MM_ADDRESS;
  logic                          AVALON_MM_READ;
  logic [DRAM_DATAWIDTH/8-1:0]   AVALON_MM_BYTEENABLE;
  logic [MAXBURST_LOG:0]         AVALON_MM_BURSTCOUNT;

  modport master (
    input  READ_REQ, READ_INITADDR, READ_NUM, READ_STRIDE,
    input  AVALON_MM_READDATA, AVALON_MM_READDATAVALID, AVALON_MM_WAITREQUEST,
    output READ_DATA, READ_DATAEN, READ_RDY, READ_DONE,
    output AVALON_MM_ADDRESS, AVALON_MM_READ, AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
  );

  modport slave (
    output READ_REQ, READ_INITADDR, READ_NUM, READ_STRIDE,
    output AVALON_MM_READDATA, AVALON_MM_READDATAVALID, AVALON_MM_WAITREQUEST,
    input  READ_DATA, READ_DATAEN, READ_RDY, READ_DONE,
    input  AVALON_MM_ADDRESS, AVALON_MM_READ, AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
  );
endinterface

// File: rtl/dram_read_pipe.sv
// dram_read_pipe: splits a READ_NUM-beat read into Avalon-MM bursts of up to
// 2^MAXBURST_LOG beats, limits in-flight beats to 2^OUTSTD_LOG, and passes the
// returned data straight through. Optional performance counters (PERF_CYCLES,
// PERF_STALLS) are built only when DRAM_READ_PIPE_PERFCNT_EN is defined.
module dram_read_pipe #(
  parameter int MAXBURST_LOG   = 4,
  parameter int READNUM_SIZE   = 31,
  parameter int DRAM_ADDRSPACE = 64,
  parameter int DRAM_DATAWIDTH = 512,
  parameter int OUTSTD_LOG     = 6
) (
  input  logic CLK,
  input  logic RST,
  dram_read_pipe_if.master bus
`ifdef DRAM_READ_PIPE_PERFCNT_EN
  ,
  output logic [31:0] PERF_CYCLES,
  output logic [31:0] PERF_STALLS
`endif
);
  localparam int NW  = READNUM_SIZE + 1;
  localparam int BCW = MAXBURST_LOG + 1;
  localparam int OW  = OUTSTD_LOG + 2;
  localparam logic [BCW-1:0] MAX_BC = BCW'(1 << MAXBURST_LOG);
  localparam logic [OW-1:0]  CREDIT = OW'(1 << OUTSTD_LOG);
  // Contiguous step: one full burst worth of bytes.
  localparam logic [DRAM_ADDRSPACE-1:0] DEF_STEP =
    DRAM_ADDRSPACE'((DRAM_DATAWIDTH / 8) * (1 << MAXBURST_LOG));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state_reg, state_next;
  logic [DRAM_ADDRSPACE-1:0] addr_reg;
  logic [DRAM_ADDRSPACE-1:0] step_reg;
  logic [NW-1:0]             bursts_left_reg;
  logic [NW-1:0]             remaining_reg, remaining_next;
  logic [BCW-1:0]            last_bc_reg;
  logic [OUTSTD_LOG:0]       outstanding_reg, outstanding_next;
  logic                      done_reg;

  logic [MAXBURST_LOG-1:0]   num_lo;
  logic [BCW-1:0]            cur_bc;
  logic [OW-1:0]             outs_sum;
  logic                      active, credit_ok, rd, accept, beat, last_beat;
  logic                      req_go, req_zero;

  assign num_lo = bus.READ_NUM[MAXBURST_LOG-1:0];

  // Handshake decode, credit check and in-flight/remaining bookkeeping.
  always_comb begin
    active    = (state_reg != IDLE);
    req_go    = (state_reg == IDLE) && bus.READ_REQ;
    req_zero  = req_go && (bus.READ_NUM == '0);
    cur_bc    = '0;
    if (state_reg == ISSUE)
      cur_bc = (bursts_left_reg == NW'(1)) ? last_bc_reg : MAX_BC;
    // Credit only grows while a burst waits, so READ never drops mid-wait.
    credit_ok = (OW'(outstanding_reg) + OW'(cur_bc)) <= CREDIT;
    rd        = (state_reg == ISSUE) && credit_ok;
    accept    = rd && !bus.AVALON_MM_WAITREQUEST;
    // Beats arriving while idle (e.g. after a reset) never touch the counters.
    beat      = active && bus.AVALON_MM_READDATAVALID;
    last_beat = beat && (remaining_reg == NW'(1));
    outs_sum  = OW'(outstanding_reg) + (accept ? OW'(cur_bc) : OW'(0));
    if (beat && (outs_sum != '0))
      outs_sum = outs_sum - OW'(1);
    outstanding_next = outs_sum[OUTSTD_LOG:0];
    remaining_next   = remaining_reg;
    if (beat && (remaining_reg != '0))
      remaining_next = remaining_reg - NW'(1);
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.READ_REQ && (bus.READ_NUM != '0)) state_next = ISSUE;
      ISSUE: begin
        if (last_beat)
          state_next = IDLE;
        else if (accept && (bursts_left_reg == NW'(1)))
          state_next = DRAIN;
      end
      DRAIN:   if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Transfer context: latched on request, stepped per accepted burst.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_reg        <= '0;
      step_reg        <= '0;
      bursts_left_reg <= '0;
      remaining_reg   <= '0;
      last_bc_reg     <= '0;
      outstanding_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= req_zero || last_beat;
      if (req_go) begin
        addr_reg        <= bus.READ_INITADDR;
        step_reg        <= (bus.READ_STRIDE == '0) ? DEF_STEP : bus.READ_STRIDE;
        bursts_left_reg <= NW'(bus.READ_NUM >> MAXBURST_LOG) + NW'(|num_lo);
        last_bc_reg     <= (num_lo == '0) ? MAX_BC : {1'b0, num_lo};
        remaining_reg   <= bus.READ_NUM;
        outstanding_reg <= '0;
      end else begin
        if (accept) begin
          addr_reg        <= addr_reg + step_reg;
          bursts_left_reg <= bursts_left_reg - NW'(1);
        end
        remaining_reg   <= remaining_next;
        outstanding_reg <= outstanding_next;
      end
    end
  end

  assign bus.READ_DATA            = bus.AVALON_MM_READDATA;
  assign bus.READ_DATAEN          = bus.AVALON_MM_READDATAVALID;
  assign bus.READ_RDY             = (state_reg == IDLE);
  assign bus.READ_DONE            = done_reg;
  assign bus.AVALON_MM_ADDRESS    = addr_reg;
  assign bus.AVALON_MM_READ       = rd;
  assign bus.AVALON_MM_BYTEENABLE = '1;
  assign bus.AVALON_MM_BURSTCOUNT = cur_bc;

`ifdef DRAM_READ_PIPE_PERFCNT_EN
  logic [31:0] perf_cycles_reg, perf_stalls_reg;
  logic        stall;

  assign stall = (state_reg == ISSUE) &&
                 ((rd && bus.AVALON_MM_WAITREQUEST) || !credit_ok);

  // Cycle count starts at 1 for the request cycle and includes the done cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_cycles_reg <= '0;
      perf_stalls_reg <= '0;
    end else if (req_go) begin
      perf_cycles_reg <= 32'd1;
      perf_stalls_reg <= '0;
    end else begin
      if (active || done_reg) perf_cycles_reg <= perf_cycles_reg + 32'd1;
      if (stall)              perf_stalls_reg <= perf_stalls_reg + 32'd1;
    end
  end

  assign PERF_CYCLES = perf_cycles_reg;
  assign PERF_STALLS = perf_stalls_reg;
`endif
endmodule

// File: tb/tb_dram_read_pipe.sv
// Directed bench for dram_read_pipe: a default-credit instance for most
// scenarios and a small-credit (OUTSTD_LOG=4) instance for back-pressure.
module tb_dram_read_pipe;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dram_read_pipe_if if0 ();
  dram_read_pipe_if if4 ();

`ifdef DRAM_READ_PIPE_PERFCNT_EN
  logic [31:0] pc0, ps0, pc4, ps4;
  dram_read_pipe dut (.CLK(CLK), .RST(RST), .bus(if0.master), .PERF_CYCLES(pc0), .PERF_STALLS(ps0));
  dram_read_pipe #(.OUTSTD_LOG(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if4.master), .PERF_CYCLES(pc4), .PERF_STALLS(ps4));
`else
  dram_read_pipe dut (.CLK(CLK), .RST(RST), .bus(if0.master));
  dram_read_pipe #(.OUTSTD_LOG(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if4.master));
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [511:0] pat(int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hA5A5_0000;
    return {16{w}};
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (if0.READ_RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b exp 1", if0.READ_RDY); end
    checks++; if (if0.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL reset_read got %0b exp 0", if0.AVALON_MM_READ); end
    checks++; if (if0.AVALON_MM_BURSTCOUNT !== 5'd0) begin errors++; $display("FAIL reset_bc got %0d exp 0", if0.AVALON_MM_BURSTCOUNT); end
    checks++; if (if0.AVALON_MM_ADDRESS !== 64'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", if0.AVALON_MM_ADDRESS); end
    checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", if0.READ_DONE); end
    checks++; if (if0.AVALON_MM_BYTEENABLE !== {64{1'b1}}) begin errors++; $display("FAIL reset_be got %h exp all ones", if0.AVALON_MM_BYTEENABLE); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_contiguous();
    logic [63:0] ea [3];
    logic [4:0]  eb [3];
    int dcnt;
    ea = '{64'h1000, 64'h1400, 64'h1800};
    eb = '{5'd16, 5'd16, 5'd8};
    dcnt = 0;
    if0.READ_REQ = 1'b1; if0.READ_INITADDR = 64'h1000; if0.READ_NUM = 32'd40; if0.READ_STRIDE = 64'd0;
    #1;
    checks++; if (if0.READ_RDY !== 1'b1) begin errors++; $display("FAIL contig_rdy_req got %0b exp 1", if0.READ_RDY); end
    tick();
    // Ignored while busy: hold REQ for one more cycle.
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++; if (if0.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL contig_read%0d got %0b exp 1", b, if0.AVALON_MM_READ); end
      checks++; if (if0.AVALON_MM_ADDRESS !== ea[b]) begin errors++; $display("FAIL contig_addr%0d got %h exp %h", b, if0.AVALON_MM_ADDRESS, ea[b]); end
      checks++; if (if0.AVALON_MM_BURSTCOUNT !== eb[b]) begin errors++; $display("FAIL contig_bc%0d got %0d exp %0d", b, if0.AVALON_MM_BURSTCOUNT, eb[b]); end
      tick();
      if0.READ_REQ = 1'b0;
    end
    #1;
    checks++; if (if0.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL contig_drain_read got %0b exp 0", if0.AVALON_MM_READ); end
    checks++; if (if0.READ_RDY !== 1'b0) begin errors++; $display("FAIL contig_drain_rdy got %0b exp 0", if0.READ_RDY); end
    for (int i = 0; i < 40; i++) begin
      if0.AVALON_MM_READDATAVALID = 1'b1; if0.AVALON_MM_READDATA = pat(i);
      #1;
      if (if0.READ_DATAEN === 1'b1) dcnt++;
      checks++; if (if0.READ_DATA !== pat(i)) begin errors++; $display("FAIL contig_data%0d got %h exp %h", i, if0.READ_DATA[31:0], pat(i) & 512'hFFFF_FFFF); end
      checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL contig_early_done%0d got %0b exp 0", i, if0.READ_DONE); end
      tick();
    end
    if0.AVALON_MM_READDATAVALID = 1'b0;
    #1;
    checks++; if (dcnt !== 40) begin errors++; $display("FAIL contig_dataen_count got %0d exp 40", dcnt); end
    checks++; if (if0.READ_DONE !== 1'b1) begin errors++; $display("FAIL contig_done got %0b exp 1", if0.READ_DONE); end
    checks++; if (if0.READ_RDY !== 1'b1) begin errors++; $display("FAIL contig_rdy_end got %0b exp 1", if0.READ_RDY); end
    tick();
    checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL contig_done_pulse got %0b exp 0", if0.READ_DONE); end
    $display("contiguous: 40 beats at 0x1000, dataen=%0d", dcnt);
  endtask

  task automatic test_zero();
    if0.READ_REQ = 1'b1; if0.READ_NUM = 32'd0; if0.READ_INITADDR = 64'h5000;
    #1;
    checks++; if (if0.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL zero_read_req got %0b exp 0", if0.AVALON_MM_READ); end
    tick();
    if0.READ_REQ = 1'b0;
    #1;
    checks++; if (if0.READ_DONE !== 1'b1) begin errors++; $display("FAIL zero_done got %0b exp 1", if0.READ_DONE); end
    checks++; if (if0.READ_RDY !== 1'b1) begin errors++; $display("FAIL zero_rdy got %0b exp 1", if0.READ_RDY); end
    checks++; if (if0.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL zero_read got %0b exp 0", if0.AVALON_MM_READ); end
    tick();
    checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %0b exp 0", if0.READ_DONE); end
    checks++; if (if0.READ_RDY !== 1'b1) begin errors++; $display("FAIL zero_rdy_after got %0b exp 1", if0.READ_RDY); end
    $display("zero: READ_NUM=0 done without traffic");
  endtask

  task automatic test_waitreq();
    if0.READ_REQ = 1'b1; if0.READ_NUM = 32'd16; if0.READ_INITADDR = 64'h2000; if0.READ_STRIDE = 64'd0;
    if0.AVALON_MM_WAITREQUEST = 1'b1;
    tick();
    if0.READ_REQ = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (if0.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL wait_read%0d got %0b exp 1", k, if0.AVALON_MM_READ); end
      checks++; if (if0.AVALON_MM_ADDRESS !== 64'h2000) begin errors++; $display("FAIL wait_addr%0d got %h exp 2000", k, if0.AVALON_MM_ADDRESS); end
      checks++; if (if0.AVALON_MM_BURSTCOUNT !== 5'd16) begin errors++; $display("FAIL wait_bc%0d got %0d exp 16", k, if0.AVALON_MM_BURSTCOUNT); end
      tick();
    end
    if0.AVALON_MM_WAITREQUEST = 1'b0;
    #1;
    checks++; if (if0.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL wait_accept_read got %0b exp 1", if0.AVALON_MM_READ); end
    tick();
    checks++; if (if0.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL wait_single_burst got %0b exp 0", if0.AVALON_MM_READ); end
    for (int i = 0; i < 16; i++) begin
      if0.AVALON_MM_READDATAVALID = 1'b1; if0.AVALON_MM_READDATA = pat(100 + i);
      tick();
    end
    if0.AVALON_MM_READDATAVALID = 1'b0;
    #1;
    checks++; if (if0.READ_DONE !== 1'b1) begin errors++; $display("FAIL wait_done got %0b exp 1", if0.READ_DONE); end
    tick();
`ifdef DRAM_READ_PIPE_PERFCNT_EN
    checks++; if (ps0 !== 32'd5) begin errors++; $display("FAIL wait_perf_stalls got %0d exp 5", ps0); end
    checks++; if (pc0 !== 32'd24) begin errors++; $display("FAIL wait_perf_cycles got %0d exp 24", pc0); end
`endif
    $display("waitreq: burst held 5 cycles then accepted");
  endtask

  task automatic test_credit();
    if4.READ_REQ = 1'b1; if4.READ_NUM = 32'd32; if4.READ_INITADDR = 64'h1000; if4.READ_STRIDE = 64'h10000;
    tick();
    if4.READ_REQ = 1'b0;
    #1;
    checks++; if (if4.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL credit_first_read got %0b exp 1", if4.AVALON_MM_READ); end
    checks++; if (if4.AVALON_MM_ADDRESS !== 64'h1000) begin errors++; $display("FAIL credit_first_addr got %h exp 1000", if4.AVALON_MM_ADDRESS); end
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (if4.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL credit_block%0d got %0b exp 0", k, if4.AVALON_MM_READ); end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      if4.AVALON_MM_READDATAVALID = 1'b1; if4.AVALON_MM_READDATA = pat(200 + i);
      #1;
      checks++; if (if4.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL credit_held%0d got %0b exp 0", i, if4.AVALON_MM_READ); end
      tick();
    end
    if4.AVALON_MM_READDATAVALID = 1'b0;
    #1;
    checks++; if (if4.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL credit_second_read got %0b exp 1", if4.AVALON_MM_READ); end
    checks++; if (if4.AVALON_MM_ADDRESS !== 64'h11000) begin errors++; $display("FAIL credit_second_addr got %h exp 11000", if4.AVALON_MM_ADDRESS); end
    checks++; if (if4.AVALON_MM_BURSTCOUNT !== 5'd16) begin errors++; $display("FAIL credit_second_bc got %0d exp 16", if4.AVALON_MM_BURSTCOUNT); end
    tick();
    checks++; if (if4.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL credit_drain_read got %0b exp 0", if4.AVALON_MM_READ); end
    for (int i = 0; i < 16; i++) begin
      if4.AVALON_MM_READDATAVALID = 1'b1;
      tick();
    end
    if4.AVALON_MM_READDATAVALID = 1'b0;
    #1;
    checks++; if (if4.READ_DONE !== 1'b1) begin errors++; $display("FAIL credit_done got %0b exp 1", if4.READ_DONE); end
    tick();
    $display("credit: second burst withheld until 16 beats returned");
  endtask

  task automatic test_reset_mid();
    int dcnt;
    dcnt = 0;
    if0.READ_REQ = 1'b1; if0.READ_NUM = 32'd48; if0.READ_INITADDR = 64'h8000; if0.READ_STRIDE = 64'd0;
    tick();
    if0.READ_REQ = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (if0.AVALON_MM_ADDRESS !== 64'h8800) begin errors++; $display("FAIL rmid_third_addr got %h exp 8800", if0.AVALON_MM_ADDRESS); end
    checks++; if (if0.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL rmid_third_read got %0b exp 1", if0.AVALON_MM_READ); end
    RST = 1'b1;
    #1;
    checks++; if (if0.AVALON_MM_READ !== 1'b0) begin errors++; $display("FAIL rmid_read got %0b exp 0", if0.AVALON_MM_READ); end
    checks++; if (if0.READ_RDY !== 1'b1) begin errors++; $display("FAIL rmid_rdy got %0b exp 1", if0.READ_RDY); end
    checks++; if (if0.AVALON_MM_ADDRESS !== 64'd0) begin errors++; $display("FAIL rmid_addr got %h exp 0", if0.AVALON_MM_ADDRESS); end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if0.AVALON_MM_READDATAVALID = 1'b1; if0.AVALON_MM_READDATA = pat(300 + i);
      #1;
      if (if0.READ_DATAEN === 1'b1) dcnt++;
      checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL rmid_late_done%0d got %0b exp 0", i, if0.READ_DONE); end
      tick();
    end
    if0.AVALON_MM_READDATAVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL rmid_idle_done%0d got %0b exp 0", i, if0.READ_DONE); end
      tick();
    end
    checks++; if (dcnt !== 8) begin errors++; $display("FAIL rmid_dataen_count got %0d exp 8", dcnt); end
    if0.READ_REQ = 1'b1; if0.READ_NUM = 32'd16; if0.READ_INITADDR = 64'h9000;
    tick();
    if0.READ_REQ = 1'b0;
    #1;
    checks++; if (if0.AVALON_MM_ADDRESS !== 64'h9000) begin errors++; $display("FAIL rmid_new_addr got %h exp 9000", if0.AVALON_MM_ADDRESS); end
    checks++; if (if0.AVALON_MM_BURSTCOUNT !== 5'd16) begin errors++; $display("FAIL rmid_new_bc got %0d exp 16", if0.AVALON_MM_BURSTCOUNT); end
    tick();
    for (int i = 0; i < 16; i++) begin
      if0.AVALON_MM_READDATAVALID = 1'b1;
      #1;
      checks++; if (if0.READ_DONE !== 1'b0) begin errors++; $display("FAIL rmid_new_early%0d got %0b exp 0", i, if0.READ_DONE); end
      tick();
    end
    if0.AVALON_MM_READDATAVALID = 1'b0;
    #1;
    checks++; if (if0.READ_DONE !== 1'b1) begin errors++; $display("FAIL rmid_new_done got %0b exp 1", if0.READ_DONE); end
    tick();
    $display("reset_mid: abandoned transfer, 8 late beats, new 16-beat read done");
  endtask

  task automatic test_wrap();
    if0.READ_REQ = 1'b1; if0.READ_NUM = 32'd32; if0.READ_INITADDR = 64'hFFFF_FFFF_FFFF_FC00; if0.READ_STRIDE = 64'd0;
    tick();
    if0.READ_REQ = 1'b0;
    #1;
    checks++; if (if0.AVALON_MM_ADDRESS !== 64'hFFFF_FFFF_FFFF_FC00) begin errors++; $display("FAIL wrap_first_addr got %h exp fffffffffffffc00", if0.AVALON_MM_ADDRESS); end
    tick();
    checks++; if (if0.AVALON_MM_ADDRESS !== 64'd0) begin errors++; $display("FAIL wrap_second_addr got %h exp 0", if0.AVALON_MM_ADDRESS); end
    checks++; if (if0.AVALON_MM_READ !== 1'b1) begin errors++; $display("FAIL wrap_second_read got %0b exp 1", if0.AVALON_MM_READ); end
    tick();
    for (int i = 0; i < 32; i++) begin
      if0.AVALON_MM_READDATAVALID = 1'b1;
      tick();
    end
    if0.AVALON_MM_READDATAVALID = 1'b0;
    #1;
    checks++; if (if0.READ_DONE !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b exp 1", if0.READ_DONE); end
    tick();
    $display("wrap: second burst address wrapped to 0");
  endtask

  initial begin
    if0.READ_REQ = 1'b0; if0.READ_INITADDR = '0; if0.READ_NUM = '0; if0.READ_STRIDE = '0;
    if0.AVALON_MM_READDATA = '0; if0.AVALON_MM_READDATAVALID = 1'b0; if0.AVALON_MM_WAITREQUEST = 1'b0;
    if4.READ_REQ = 1'b0; if4.READ_INITADDR = '0; if4.READ_NUM = '0; if4.READ_STRIDE = '0;
    if4.AVALON_MM_READDATA = '0; if4.AVALON_MM_READDATAVALID = 1'b0; if4.AVALON_MM_WAITREQUEST = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    test_reset();
    RST = 1'b0;
    tick();
    test_contiguous();
    test_zero();
    test_waitreq();
    test_credit();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_read_pipe.md
DRAM_READ_PIPE -- requirements
Module: dram_read_pipe

Interface
REQ-001 SHALL have parameter MAXBURST_LOG, default 4: max burst = 2^MAXBURST_LOG beats.
REQ-002 SHALL have parameter READNUM_SIZE, default 31: READ_NUM width minus 1.
REQ-003 SHALL have parameter DRAM_ADDRSPACE, default 64: address width.
REQ-004 SHALL have parameter DRAM_DATAWIDTH, default 512: beat width, multiple of 8.
REQ-005 SHALL have parameter OUTSTD_LOG, default 6, at least MAXBURST_LOG: outstanding-beat limit = 2^OUTSTD_LOG.
REQ-006 SHALL have ports: CLK in 1, the single clock; RST in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: READ_REQ in 1, start; READ_INITADDR in DRAM_ADDRSPACE, byte address; READ_NUM in READNUM_SIZE+1, beat count; READ_STRIDE in DRAM_ADDRSPACE, byte step between bursts, where 0 = contiguous.
REQ-008 SHALL have ports: READ_DATA out DRAM_DATAWIDTH; READ_DATAEN out 1; READ_RDY out 1, idle; READ_DONE out 1, one-cycle completion pulse.
REQ-009 SHALL have Avalon-MM ports: AVALON_MM_READDATA in DRAM_DATAWIDTH; AVALON_MM_READDATAVALID in 1; AVALON_MM_WAITREQUEST in 1; AVALON_MM_ADDRESS out DRAM_ADDRSPACE; AVALON_MM_READ out 1; AVALON_MM_BYTEENABLE out DRAM_DATAWIDTH/8, all ones; AVALON_MM_BURSTCOUNT out MAXBURST_LOG+1.

Function
REQ-010 SHALL have states IDLE, ISSUE, DRAIN; READ_RDY SHALL be 1 only in IDLE.
REQ-011 SHALL, in IDLE with READ_REQ=1, latch address, bursts = ceil(READ_NUM/2^MAXBURST_LOG), last burst = READ_NUM mod 2^MAXBURST_LOG (2^MAXBURST_LOG if 0), remaining beats = READ_NUM, step = READ_STRIDE or DRAM_DATAWIDTH/8 * 2^MAXBURST_LOG if 0, then enter ISSUE.
REQ-012 SHALL, for READ_NUM=0, skip Avalon traffic, pulse READ_DONE the cycle after the request and stay in IDLE.
REQ-013 SHALL, in ISSUE, assert AVALON_MM_READ when outstanding + current burstcount <= 2^OUTSTD_LOG; address and burstcount SHALL hold stable while WAITREQUEST=1.
REQ-014 SHALL count a burst accepted when READ=1 and WAITREQUEST=0; the next burst SHALL be presented on the following cycle with no idle gap if credit allows.
REQ-015 SHALL advance address by step per accepted burst, modulo 2^DRAM_ADDRSPACE, wrapping silently.
REQ-016 SHALL update outstanding each cycle as outstanding + accepted burstcount - READDATAVALID, covering simultaneous events, and SHALL saturate at 0 on a spurious READDATAVALID.
REQ-017 SHALL enter DRAIN after the last burst is accepted, with READ deasserted the same edge.
REQ-018 SHALL decrement remaining beats per READDATAVALID in ISSUE/DRAIN; when it reaches 0, READ_DONE SHALL pulse for 1 cycle and state SHALL return to IDLE.
REQ-019 SHALL pass READ_DATA/READ_DATAEN combinationally from READDATA/READDATAVALID with zero latency, in any state.
REQ-020 SHALL ignore READ_REQ outside IDLE.

Reset
REQ-021 SHALL, on RST, asynchronously force state IDLE, all counters and address to 0, AVALON_MM_READ=0, AVALON_MM_BURSTCOUNT=0, AVALON_MM_ADDRESS=0, READ_DONE=0, READ_RDY=1.
REQ-022 SHALL, on reset mid-transfer, abandon the transfer, emit no READ_DONE, and leave counters unaffected by late READDATAVALID beats, which still pass through to READ_DATAEN.

Configuration
REQ-023 SHALL, with DRAM_READ_PIPE_PERFCNT_EN defined, add outputs PERF_CYCLES out 32, cycles from accepted READ_REQ to READ_DONE inclusive, and PERF_STALLS out 32, ISSUE cycles with READ=1 and WAITREQUEST=1 plus ISSUE cycles blocked by credit; both SHALL clear on request acceptance and on RST, hold after done, and wrap at 2^32.
REQ-024 SHALL, without DRAM_READ_PIPE_PERFCNT_EN, omit those ports and their logic entirely.

Verification
REQ-025 SHALL cover: READ_NUM=40, INITADDR=0x1000, STRIDE=0, WAITREQUEST=0 -> bursts 16@0x1000, 16@0x1400, 8@0x1800 on consecutive cycles; 40 DATAEN; READ_DONE once, after 40th beat.
REQ-026 SHALL cover: READ_NUM=32, STRIDE=0x10000, OUTSTD_LOG=4, no returned data -> 1st burst issued, 2nd withheld until 16 beats return, then issued at 0x11000-offset address INITADDR+0x10000.
REQ-027 SHALL cover: WAITREQUEST high for 5 cycles on first burst -> address/burstcount stable all 5 cycles; one burst accepted; PERF_STALLS=5 with macro.
REQ-028 SHALL cover: READ_NUM=0 -> no AVALON_MM_READ; READ_DONE one cycle after request; READ_RDY stays 1.
REQ-029 SHALL cover: RST pulsed after 2 of 3 bursts accepted, with 8 beats returning later -> READ=0 immediately; READ_RDY=1; 8 DATAEN pulses; no READ_DONE; next request of 16 completes normally.
REQ-030 SHALL cover: INITADDR=0xFFFF_FFFF_FFFF_FC00, READ_NUM=32 -> second burst address wraps to 0x0.
